// File: rtl/phy_to_llr_unpacker_pkg.sv
// Shared definitions for the PHY-to-LLR unpacker.
// Holds the FSM state encoding, the default geometry with the constants
// derived from it, and a configuration check used at elaboration.
package phy_to_llr_unpacker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_DW         = 16;
    localparam int DEF_BEAT_WORDS = 8;
    localparam int DEF_LANES      = 2;
    localparam int DEF_CNT_W      = 16;

    // Derived values for the default geometry.
    localparam int GROUPS_PER_BEAT = DEF_BEAT_WORDS / (2 * DEF_LANES);
    localparam int IDX_W           = $clog2(DEF_BEAT_WORDS);

    // A beat must split into a whole number of output groups.
    function automatic bit beat_cfg_ok(input int beat_words, input int lanes);
        return (lanes > 0) && ((beat_words % (2 * lanes)) == 0);
    endfunction

endpackage

// File: rtl/phy_to_llr_unpacker_beat_lane_mux.sv
// Combinational lane selection from a held IQ beat.
// Ports:
//   beat     held IQ beat, RE k has I at word 2k and Q at word 2k+1
//   grp_idx  group index within the beat
//   re_left  REs still owed to the user, counted from this group's lane 0
//   lane_i   lane n I at [n*DW +: DW]; zero for lanes past the user's end
//   lane_q   lane n Q, same packing and masking
module phy_to_llr_unpacker_beat_lane_mux #(
    parameter int DW         = 16,
    parameter int BEAT_WORDS = 8,
    parameter int LANES      = 2,
    parameter int CNT_W      = 16,
    parameter int IW         = 3
) (
    input  logic [BEAT_WORDS*DW-1:0] beat,
    input  logic [IW-1:0]            grp_idx,
    input  logic [CNT_W-1:0]         re_left,
    output logic [LANES*DW-1:0]      lane_i,
    output logic [LANES*DW-1:0]      lane_q
);

    logic [DW-1:0] words [BEAT_WORDS];
    logic [IW-1:0] wsel;

    always_comb begin
        for (int w = 0; w < BEAT_WORDS; w++) begin
            words[w] = beat[w*DW +: DW];
        end
    end

    always_comb begin
        lane_i = '0;
        lane_q = '0;
        wsel   = '0;
        for (int n = 0; n < LANES; n++) begin
            wsel = IW'(int'(grp_idx) * 2 * LANES + 2 * n);
            // re_left is at least 1 in any presented group, so lane 0 is always live.
            if (re_left > CNT_W'(n)) begin
                lane_i[n*DW +: DW] = words[wsel];
                lane_q[n*DW +: DW] = words[wsel + IW'(1)];
            end
        end
    end

endmodule

// File: rtl/phy_to_llr_unpacker.sv
// Unpacks packed IQ and noise beats from two FIFOs into LANES-wide RE groups
// for the LLR demapper, with valid/ready flow control and per-user framing.
// Ports:
//   i_core_clk, i_rx_rst           clock, async active-high reset
//   i_start                        one-cycle pulse, latches config and starts a user
//   i_iq_noise_rate                groups per noise word (0 behaves as 1)
//   i_cur_user_re_amounts          REs in this user (0 finishes at once)
//   i_iq_fifo_*, o_iq_fifo_rd_en   IQ FIFO, data valid the cycle after rd_en
//   i_noise_fifo_*, o_noise_fifo_rd_en  noise FIFO, same timing
//   i_llr_ready                    downstream accept
//   o_data_strobe, o_re_data_i/q, o_noise_data, o_last   output group
//   o_busy, o_done                 user in progress / one-cycle completion pulse
// Handshake: a group transfers on a cycle where o_data_strobe and i_llr_ready
// are both 1; while o_data_strobe is 1 and i_llr_ready is 0 every output holds.
module phy_to_llr_unpacker
    import phy_to_llr_unpacker_pkg::*;
#(
    parameter int DW         = DEF_DW,
    parameter int BEAT_WORDS = DEF_BEAT_WORDS,
    parameter int LANES      = DEF_LANES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     i_core_clk,
    input  logic                     i_rx_rst,
    input  logic                     i_start,
    input  logic [CNT_W-1:0]         i_iq_noise_rate,
    input  logic [CNT_W-1:0]         i_cur_user_re_amounts,
    input  logic [BEAT_WORDS*DW-1:0] i_iq_fifo_data,
    input  logic                     i_iq_fifo_empty,
    output logic                     o_iq_fifo_rd_en,
    input  logic [BEAT_WORDS*DW-1:0] i_noise_fifo_data,
    input  logic                     i_noise_fifo_empty,
    output logic                     o_noise_fifo_rd_en,
    input  logic                     i_llr_ready,
    output logic                     o_data_strobe,
    output logic [LANES*DW-1:0]      o_re_data_i,
    output logic [LANES*DW-1:0]      o_re_data_q,
    output logic [DW-1:0]            o_noise_data,
    output logic                     o_last,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int GPB = BEAT_WORDS / (2 * LANES);
    localparam int IW  = $clog2(BEAT_WORDS);

    if (!beat_cfg_ok(BEAT_WORDS, LANES)) begin : g_cfg_check
        $error("phy_to_llr_unpacker: BEAT_WORDS must be a multiple of 2*LANES");
    end

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        rate_r, re_r, grp_total, grp_cnt, re_base, rep_cnt;
    logic [IW-1:0]           grp_idx, noise_idx;
    logic                    need_iq, need_nz, iq_rd_d, nz_rd_d;
    logic [BEAT_WORDS*DW-1:0] iq_hold, nz_hold;
    logic [CNT_W:0]          re_round;
    logic                    iq_rd, nz_rd, emit, accept, is_last;
    logic                    grp_wrap, rep_wrap, nz_wrap;
    logic [LANES*DW-1:0]     mux_i, mux_q;

    assign re_round = {1'b0, i_cur_user_re_amounts} + (CNT_W+1)'(LANES - 1);

    assign emit     = (state == ST_EMIT);
    assign accept   = emit && i_llr_ready;
    assign is_last  = (grp_cnt == grp_total - CNT_W'(1));
    assign grp_wrap = (grp_idx == IW'(GPB - 1));
    assign rep_wrap = (rep_cnt == rate_r - CNT_W'(1));
    assign nz_wrap  = rep_wrap && (noise_idx == IW'(BEAT_WORDS - 1));

    // Reads are issued only in FETCH and never toward an empty FIFO.
    assign iq_rd = (state == ST_FETCH) && need_iq && !i_iq_fifo_empty;
    assign nz_rd = (state == ST_FETCH) && need_nz && !i_noise_fifo_empty;

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt = (i_cur_user_re_amounts == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Leave once every outstanding read has been issued (possibly this cycle).
                if (!((need_iq && !iq_rd) || (need_nz && !nz_rd))) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: state_nxt = ST_EMIT;
            ST_EMIT: begin
                if (accept) begin
                    if (is_last) begin
                        state_nxt = ST_DONE;
                    end else if (grp_wrap || nz_wrap) begin
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            rate_r    <= '0;
            re_r      <= '0;
            grp_total <= '0;
            grp_cnt   <= '0;
            re_base   <= '0;
            rep_cnt   <= '0;
            grp_idx   <= '0;
            noise_idx <= '0;
            need_iq   <= 1'b0;
            need_nz   <= 1'b0;
            iq_rd_d   <= 1'b0;
            nz_rd_d   <= 1'b0;
            iq_hold   <= '0;
            nz_hold   <= '0;
        end else begin
            // FIFO data arrives one cycle after its read; IQ may land while
            // still in FETCH waiting for the noise FIFO, and vice versa.
            iq_rd_d <= iq_rd;
            nz_rd_d <= nz_rd;
            if (iq_rd_d) iq_hold <= i_iq_fifo_data;
            if (nz_rd_d) nz_hold <= i_noise_fifo_data;
            if (iq_rd) need_iq <= 1'b0;
            if (nz_rd) need_nz <= 1'b0;

            if (state == ST_IDLE && i_start) begin
                rate_r    <= (i_iq_noise_rate == '0) ? CNT_W'(1) : i_iq_noise_rate;
                re_r      <= i_cur_user_re_amounts;
                grp_total <= CNT_W'(re_round / (CNT_W+1)'(LANES));
                grp_cnt   <= '0;
                re_base   <= '0;
                rep_cnt   <= '0;
                grp_idx   <= '0;
                noise_idx <= '0;
                need_iq   <= (i_cur_user_re_amounts != '0);
                need_nz   <= (i_cur_user_re_amounts != '0);
            end

            // The final acceptance leaves everything as is: leftovers are dropped.
            if (accept && !is_last) begin
                grp_cnt <= grp_cnt + CNT_W'(1);
                re_base <= re_base + CNT_W'(LANES);
                if (grp_wrap) begin
                    grp_idx <= '0;
                    need_iq <= 1'b1;
                end else begin
                    grp_idx <= grp_idx + IW'(1);
                end
                if (rep_wrap) begin
                    rep_cnt <= '0;
                    if (nz_wrap) begin
                        noise_idx <= '0;
                        need_nz   <= 1'b1;
                    end else begin
                        noise_idx <= noise_idx + IW'(1);
                    end
                end else begin
                    rep_cnt <= rep_cnt + CNT_W'(1);
                end
            end
        end
    end

    phy_to_llr_unpacker_beat_lane_mux #(
        .DW         (DW),
        .BEAT_WORDS (BEAT_WORDS),
        .LANES      (LANES),
        .CNT_W      (CNT_W),
        .IW         (IW)
    ) u_lane_mux (
        .beat    (iq_hold),
        .grp_idx (grp_idx),
        .re_left (re_r - re_base),
        .lane_i  (mux_i),
        .lane_q  (mux_q)
    );

    assign o_iq_fifo_rd_en    = iq_rd;
    assign o_noise_fifo_rd_en = nz_rd;
    assign o_data_strobe      = emit;
    assign o_re_data_i        = emit ? mux_i : '0;
    assign o_re_data_q        = emit ? mux_q : '0;
    assign o_noise_data       = emit ? nz_hold[int'(noise_idx)*DW +: DW] : '0;
    assign o_last             = emit && is_last;
    assign o_busy             = (state != ST_IDLE);
    assign o_done             = (state == ST_DONE);

endmodule

// File: tb/tb_phy_to_llr_unpacker.sv
module tb_phy_to_llr_unpacker;

    localparam int DW    = 16;
    localparam int BW    = 8;
    localparam int LANES = 2;
    localparam int CNT_W = 16;
    localparam int RPB   = BW / 2;                 // REs per IQ beat
    localparam int EW    = 1 + DW + 2 * LANES * DW; // {last, noise, q, i}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                  i_start;
    logic [CNT_W-1:0]      rate_in, re_in;
    logic [BW*DW-1:0]      iq_data, nz_data;
    logic                  iq_empty, nz_empty, iq_rd, nz_rd, ready;
    logic                  strobe, last, busy, done;
    logic [LANES*DW-1:0]   re_i, re_q;
    logic [DW-1:0]         noise_out;

    phy_to_llr_unpacker #(.DW(DW), .BEAT_WORDS(BW), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .i_core_clk            (clk),
        .i_rx_rst              (rst),
        .i_start               (i_start),
        .i_iq_noise_rate       (rate_in),
        .i_cur_user_re_amounts (re_in),
        .i_iq_fifo_data        (iq_data),
        .i_iq_fifo_empty       (iq_empty),
        .o_iq_fifo_rd_en       (iq_rd),
        .i_noise_fifo_data     (nz_data),
        .i_noise_fifo_empty    (nz_empty),
        .o_noise_fifo_rd_en    (nz_rd),
        .i_llr_ready           (ready),
        .o_data_strobe         (strobe),
        .o_re_data_i           (re_i),
        .o_re_data_q           (re_q),
        .o_noise_data          (noise_out),
        .o_last                (last),
        .o_busy                (busy),
        .o_done                (done)
    );

    // ---------------- scoreboard state ----------------
    int               n_vec = 0;
    int               n_err = 0;
    logic [EW-1:0]    exp_q[$];
    logic [BW*DW-1:0] iq_src[$], nz_src[$], iq_all[$], nz_all[$];
    int               iq_reads, nz_reads, acc_cnt;
    time              t_last_acc, t_done;
    logic [EW-1:0]    mon_e;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FIFO models: registered read data, one beat per rd_en.
    always @(posedge clk) begin
        if (iq_rd) begin
            check("iq_rd_while_empty", 128'(iq_empty), 128'(0));
            iq_reads++;
            if (iq_src.size() > 0) iq_data <= iq_src.pop_front();
            else                   iq_data <= '0;
        end
        if (nz_rd) begin
            check("noise_rd_while_empty", 128'(nz_empty), 128'(0));
            nz_reads++;
            if (nz_src.size() > 0) nz_data <= nz_src.pop_front();
            else                   nz_data <= '0;
        end
    end

    // Output monitor: every accepted group is compared with the model.
    always @(negedge clk) begin
        if (strobe && ready) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 128'(1), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_data", 128'({last, noise_out, re_q, re_i}), 128'(mon_e));
            end
            if (last) t_last_acc = $time;
        end
    end

    // ---------------- reference model ----------------
    // Group g carries REs g*LANES+n; RE r lives in IQ beat r/RPB at pair r%RPB.
    // Noise word index is g/rate, laid out BW words per noise beat.
    task automatic build_expected(input int rate, input int re);
        int er, g_tot, r, k, w;
        logic [BW*DW-1:0]    b;
        logic [LANES*DW-1:0] ei, eq;
        logic [DW-1:0]       nw;
        er    = (rate == 0) ? 1 : rate;
        g_tot = (re + LANES - 1) / LANES;
        for (int g = 0; g < g_tot; g++) begin
            ei = '0;
            eq = '0;
            for (int n = 0; n < LANES; n++) begin
                r = g * LANES + n;
                if (r < re) begin
                    b = iq_all[r / RPB];
                    k = r % RPB;
                    ei[n*DW +: DW] = b[(2*k)*DW +: DW];
                    eq[n*DW +: DW] = b[(2*k+1)*DW +: DW];
                end
            end
            w  = g / er;
            b  = nz_all[w / BW];
            nw = b[(w % BW)*DW +: DW];
            exp_q.push_back({(g == g_tot - 1), nw, eq, ei});
        end
    endtask

    task automatic prep_user(input int rate, input int re, input bit pat_const);
        logic [BW*DW-1:0] cb, rb;
        int n_iq, n_nz;
        cb = 128'h0077_0066_0055_0044_0033_0022_0011_000C;
        iq_src.delete(); nz_src.delete(); exp_q.delete();
        n_iq = re / RPB + 2;
        n_nz = ((re + LANES - 1) / LANES) / BW + 2;
        for (int i = 0; i < n_iq; i++) begin
            for (int w = 0; w < BW; w++) rb[w*DW +: DW] = DW'($urandom);
            iq_src.push_back(pat_const ? cb : rb);
        end
        for (int i = 0; i < n_nz; i++) begin
            for (int w = 0; w < BW; w++) rb[w*DW +: DW] = DW'($urandom);
            nz_src.push_back(pat_const ? cb : rb);
        end
        iq_all = iq_src;
        nz_all = nz_src;
        iq_reads = 0; nz_reads = 0; acc_cnt = 0;
        build_expected(rate, re);
    endtask

    // ---------------- driver tasks ----------------
    // Leaves the caller at posedge+1 of cycle 1 (i_start is high in cycle 0).
    task automatic pulse_start(input int rate, input int re);
        @(posedge clk); #1;
        i_start = 1'b1; rate_in = CNT_W'(rate); re_in = CNT_W'(re);
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_ready, input bit rnd_empty, input bit script,
                             output int done_cyc, output int first_rd, output int first_st,
                             output logic [1:0] rd_at1);
        int c;
        bit seen;
        c = 1; seen = 0; done_cyc = -1; first_rd = -1; first_st = -1; rd_at1 = 2'b00;
        while (!seen && c < 20000) begin
            if (c == 1) begin
                rd_at1 = {iq_rd, nz_rd};
                check("busy_after_start", 128'(busy), 128'(1));
            end
            if (first_rd < 0 && (iq_rd || nz_rd)) first_rd = c;
            if (first_st < 0 && strobe) first_st = c;
            if (done) begin
                seen = 1; done_cyc = c; t_done = $time;
                check("busy_at_done", 128'(busy), 128'(1));
            end else begin
                if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
                if (rnd_empty) begin
                    iq_empty = ($urandom_range(0, 3) == 0);
                    nz_empty = ($urandom_range(0, 3) == 0);
                end
                if (script) begin
                    if (c == 50)  begin i_start = 1'b1; rate_in = 16'd1; re_in = 16'd2; end
                    if (c == 51)  i_start  = 1'b0;
                    if (c == 100) nz_empty = 1'b1;
                    if (c == 106) iq_empty = 1'b1;
                    if (c == 140) nz_empty = 1'b0;
                    if (c == 146) iq_empty = 1'b0;
                end
                @(posedge clk); #1;
                c++;
            end
        end
        if (!seen) check("done_timeout", 128'(0), 128'(1));
        ready = 1'b1; iq_empty = 1'b0; nz_empty = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", 128'(done), 128'(0));
        check("busy_clear_after_done", 128'(busy), 128'(0));
    endtask

    task automatic finish_user(input int re, input int exp_st, input int exp_iq, input int exp_nz,
                               input int done_cyc);
        check("groups_accepted", 128'(acc_cnt), 128'(exp_st));
        check("model_queue_drained", 128'(exp_q.size()), 128'(0));
        check("iq_read_count", 128'(iq_reads), 128'(exp_iq));
        check("noise_read_count", 128'(nz_reads), 128'(exp_nz));
        if (re == 0) check("zero_re_done_by_t2", 128'(done_cyc >= 1 && done_cyc <= 2), 128'(1));
        else         check("done_after_last_accept", 128'(t_done - t_last_acc), 128'(6));
    endtask

    typedef struct {
        int rate; int re; bit pat_const; bit rnd_ready; bit rnd_empty;
        int exp_st; int exp_iq; int exp_nz;
    } vec_t;

    task automatic run_user(input vec_t v, input bit timing);
        int dc, fr, fs;
        logic [1:0] r1;
        prep_user(v.rate, v.re, v.pat_const);
        pulse_start(v.rate, v.re);
        wait_done(v.rnd_ready, v.rnd_empty, 1'b0, dc, fr, fs, r1);
        if (timing) begin
            check("start_rd_both_at_1", 128'(r1), 128'(2'b11));
            check("start_first_rd_cycle", 128'(fr), 128'(1));
            check("start_first_strobe_cycle", 128'(fs), 128'(3));
        end
        if (v.re == 0) check("zero_re_no_read", 128'(fr), 128'(-1));
        finish_user(v.re, v.exp_st, v.exp_iq, v.exp_nz, dc);
    endtask

    // ---------------- hand-written sequences ----------------
    task automatic bp_test();
        int dc, fr, fs;
        logic [1:0] r1;
        logic [2*LANES*DW+DW-1:0] snap;
        prep_user(6, 40, 1'b0);
        ready = 1'b0;
        pulse_start(6, 40);
        for (int i = 0; i < 10 && !strobe; i++) begin
            @(posedge clk); #1;
        end
        check("bp_first_strobe_seen", 128'(strobe), 128'(1));
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        snap = {noise_out, re_q, re_i};
        check("bp_second_group_shown", 128'(strobe), 128'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_strobe_held", 128'(strobe), 128'(1));
            check("bp_data_held", 128'({noise_out, re_q, re_i}), 128'(snap));
            check("bp_no_fifo_read", 128'({iq_rd, nz_rd}), 128'(0));
        end
        ready = 1'b1;
        wait_done(1'b0, 1'b0, 1'b0, dc, fr, fs, r1);
        finish_user(40, 20, 10, 1, dc);
    endtask

    task automatic empty_test();
        int dc, fr, fs;
        logic [1:0] r1;
        prep_user(2, 400, 1'b0);
        pulse_start(2, 400);
        wait_done(1'b0, 1'b0, 1'b1, dc, fr, fs, r1);
        finish_user(400, 200, 100, 13, dc);
    endtask

    task automatic reset_test();
        prep_user(3, 200, 1'b0);
        pulse_start(3, 200);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs_zero",
              128'({strobe, iq_rd, nz_rd, last, busy, done, noise_out, re_q, re_i}), 128'(0));
        repeat (2) @(negedge clk);
        check("midrst_held_idle", 128'({busy, iq_rd, nz_rd, strobe}), 128'(0));
        rst = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- main ----------------
    vec_t tbl[10];

    initial begin
        int rate, re, g, er, ni, nn, dc, fr, fs;
        logic [1:0] r1;
        vec_t rv;
        rst = 1'b1; i_start = 1'b0; rate_in = '0; re_in = '0;
        iq_data = '0; nz_data = '0; iq_empty = 1'b0; nz_empty = 1'b0; ready = 1'b1;
        t_last_acc = 0; t_done = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs_zero",
              128'({strobe, iq_rd, nz_rd, last, busy, done, noise_out, re_q, re_i}), 128'(0));
        rst = 1'b0;

        //           rate  re   const rdy  emp   strobes iq   noise
        tbl[0] = '{  6,   1797, 1'b1, 1'b0, 1'b0, 899,    450, 19 };
        tbl[1] = '{  0,   5,    1'b0, 1'b1, 1'b0, 3,      2,   1  };
        tbl[2] = '{  1,   17,   1'b0, 1'b1, 1'b1, 9,      5,   2  };
        tbl[3] = '{  3,   4,    1'b0, 1'b0, 1'b1, 2,      1,   1  };
        tbl[4] = '{  2,   64,   1'b0, 1'b1, 1'b1, 32,     16,  2  };
        tbl[5] = '{  100, 3,    1'b0, 1'b1, 1'b0, 2,      1,   1  };
        tbl[6] = '{  0,   0,    1'b0, 1'b0, 1'b0, 0,      0,   0  };
        tbl[7] = '{  1,   1,    1'b0, 1'b1, 1'b1, 1,      1,   1  };
        tbl[8] = '{  8,   16,   1'b0, 1'b0, 1'b0, 8,      4,   1  };
        tbl[9] = '{  1,   32,   1'b0, 1'b0, 1'b0, 16,     8,   2  };

        for (int i = 0; i < 10; i++) begin
            run_user(tbl[i], i == 0);
            if (i == 2) bp_test();
            if (i == 4) empty_test();
            if (i == 5) reset_test();
        end

        for (int i = 0; i < 6; i++) begin
            rate = $urandom_range(0, 9);
            re   = $urandom_range(0, 300);
            g    = (re + LANES - 1) / LANES;
            er   = (rate == 0) ? 1 : rate;
            ni   = (re + RPB - 1) / RPB;
            nn   = (g == 0) ? 0 : (((g + er - 1) / er) + BW - 1) / BW;
            rv   = '{rate, re, 1'b0, 1'b1, 1'b1, g, ni, nn};
            run_user(rv, 1'b0);
        end

        // Same DUT, no reset in between: a final fixed user after random traffic.
        prep_user(4, 10, 1'b1);
        pulse_start(4, 10);
        wait_done(1'b0, 1'b0, 1'b0, dc, fr, fs, r1);
        finish_user(10, 5, 3, 1, dc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
